// File: rtl/mask_pkg.sv
// Shared defaults and derived widths for the mask upscaler and its line banks.
package mask_pkg;

    localparam int unsigned HRES_DEF        = 1280;
    localparam int unsigned VRES_DEF        = 720;
    localparam int unsigned DATA_WIDTH_DEF  = 1;
    localparam int unsigned KERNEL_SIZE_DEF = 4;

    localparam int unsigned HWIDTH_DEF = $clog2(HRES_DEF);
    localparam int unsigned VWIDTH_DEF = $clog2(VRES_DEF);
    localparam int unsigned CW_DEF     = $clog2(KERNEL_SIZE_DEF);
    localparam int unsigned BCOLS_DEF  = HRES_DEF / KERNEL_SIZE_DEF;

endpackage

// File: rtl/upscale_line_bank.sv
// One binned line of pixels: written by the binning side, read by the display side.
module upscale_line_bank
    import mask_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned DEPTH      = BCOLS_DEF,
    parameter int unsigned AW         = HWIDTH_DEF - CW_DEF
) (
    input  logic                  clk_in,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    xilinx_true_dual_port_read_first_1_clock_ram #(
        .RAM_WIDTH (DATA_WIDTH),
        .RAM_DEPTH (DEPTH),
        .ADDR_W    (AW)
    ) u_ram (
        .clka  (clk_in),
        .wea   (wr_en),
        .addra (wr_addr),
        .dina  (wr_data),
        .enb   (rd_en),
        .addrb (rd_addr),
        .doutb (rd_data)
    );

endmodule

// File: rtl/xilinx_true_dual_port_read_first_1_clock_ram.sv
// Single-clock dual-port block RAM, port A write path, port B registered read-first path.
module xilinx_true_dual_port_read_first_1_clock_ram #(
    parameter int unsigned RAM_WIDTH = 1,
    parameter int unsigned RAM_DEPTH = 320,
    parameter int unsigned ADDR_W    = 9
) (
    input  logic                 clka,
    input  logic                 wea,
    input  logic [ADDR_W-1:0]    addra,
    input  logic [RAM_WIDTH-1:0] dina,
    input  logic                 enb,
    input  logic [ADDR_W-1:0]    addrb,
    output logic [RAM_WIDTH-1:0] doutb
);

    logic [RAM_WIDTH-1:0] mem_q [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] doutb_q;

    // Nonblocking update makes a same-address read return the pre-write word.
    always_ff @(posedge clka) begin
        if (wea) begin
            mem_q[addra] <= dina;
        end
        if (enb) begin
            doutb_q <= mem_q[addrb];
        end
    end

    assign doutb = doutb_q;

endmodule

// File: rtl/mask_upscaler.sv
// Nearest-neighbour upscaler: two ping-pong line banks of binned pixels replayed at full resolution.
// Optional UPSCALER_MISS_HOLD_EN: on a row miss, show the other bank's pixel if that bank is ready.
module mask_upscaler
    import mask_pkg::*;
#(
    parameter  int unsigned HRES        = HRES_DEF,
    parameter  int unsigned VRES        = VRES_DEF,
    parameter  int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter  int unsigned KERNEL_SIZE = KERNEL_SIZE_DEF,
    localparam int unsigned HWIDTH      = $clog2(HRES),
    localparam int unsigned VWIDTH      = $clog2(VRES),
    localparam int unsigned CW          = $clog2(KERNEL_SIZE),
    localparam int unsigned BCOLS       = HRES / KERNEL_SIZE,
    localparam int unsigned BAW         = HWIDTH - CW,
    localparam int unsigned RW          = VWIDTH - CW
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [BAW-1:0]        hcount_in,
    input  logic [RW-1:0]         vcount_in,
    input  logic [DATA_WIDTH-1:0] pixel_data_in,
    input  logic                  data_valid_in,
    input  logic [HWIDTH-1:0]     hcount_disp_in,
    input  logic [VWIDTH-1:0]     vcount_disp_in,
    input  logic                  disp_valid_in,
    output logic [DATA_WIDTH-1:0] pixel_data_out,
    output logic [HWIDTH-1:0]     hcount_out,
    output logic [VWIDTH-1:0]     vcount_out,
    output logic                  data_valid_out,
    output logic                  row_miss_out
);

    logic [1:0]         ready_q, ready_d;
    logic [1:0][RW-1:0] tag_q, tag_d;

    logic [RW-1:0]      rd_row;
    logic [BAW-1:0]     rd_col;
    logic               rd_bank;
    logic               wr_bank;
    logic               hit, miss, consume, wr_first, wr_last;
    logic [1:0]         sel;
    logic [1:0][DATA_WIDTH-1:0] rd_data;

    logic                  s1_valid_q, s1_valid_d;
    logic                  s1_miss_q, s1_miss_d;
    logic [1:0]            s1_sel_q, s1_sel_d;
    logic [HWIDTH-1:0]     s1_hcount_q, s1_hcount_d;
    logic [VWIDTH-1:0]     s1_vcount_q, s1_vcount_d;

    logic [DATA_WIDTH-1:0] pix_q, pix_d;
    logic [HWIDTH-1:0]     hcount_q, hcount_d;
    logic [VWIDTH-1:0]     vcount_q, vcount_d;
    logic                  valid_q, valid_d;
    logic                  miss_q, miss_d;

    // Read-side lookup against the bank selected by the coarse row LSB.
    always_comb begin
        rd_row   = vcount_disp_in[VWIDTH-1:CW];
        rd_col   = hcount_disp_in[HWIDTH-1:CW];
        rd_bank  = rd_row[0];
        wr_bank  = vcount_in[0];
        hit      = disp_valid_in & ready_q[rd_bank] & (tag_q[rd_bank] == rd_row);
        miss     = disp_valid_in & ~hit;
        consume  = hit & (hcount_disp_in == HWIDTH'(HRES - 1))
                       & (vcount_disp_in[CW-1:0] == CW'(KERNEL_SIZE - 1));
        wr_first = data_valid_in & (hcount_in == '0);
        wr_last  = data_valid_in & (hcount_in == BAW'(BCOLS - 1));

        sel = 2'b00;
        if (hit) begin
            sel[rd_bank] = 1'b1;
        end
`ifdef UPSCALER_MISS_HOLD_EN
        else if (miss && ready_q[~rd_bank]) begin
            sel[~rd_bank] = 1'b1;
        end
`endif
    end

    // Bank status: a completed write row outranks the display releasing that bank.
    always_comb begin
        ready_d = ready_q;
        tag_d   = tag_q;
        if (consume) begin
            ready_d[rd_bank] = 1'b0;
        end
        if (wr_first) begin
            ready_d[wr_bank] = 1'b0;
        end
        if (wr_last) begin
            ready_d[wr_bank] = 1'b1;
            tag_d[wr_bank]   = vcount_in;
        end
    end

    // Stage 1 aligns with the RAM read; stage 2 selects and registers the pixel.
    always_comb begin
        s1_valid_d  = disp_valid_in;
        s1_miss_d   = miss;
        s1_sel_d    = sel;
        s1_hcount_d = hcount_disp_in;
        s1_vcount_d = vcount_disp_in;

        valid_d  = s1_valid_q;
        miss_d   = s1_miss_q;
        hcount_d = s1_hcount_q;
        vcount_d = s1_vcount_q;
        pix_d    = '0;
        if (s1_sel_q[0]) begin
            pix_d = rd_data[0];
        end else if (s1_sel_q[1]) begin
            pix_d = rd_data[1];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ready_q     <= '0;
            tag_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_miss_q   <= 1'b0;
            s1_sel_q    <= '0;
            s1_hcount_q <= '0;
            s1_vcount_q <= '0;
            pix_q       <= '0;
            hcount_q    <= '0;
            vcount_q    <= '0;
            valid_q     <= 1'b0;
            miss_q      <= 1'b0;
        end else begin
            ready_q     <= ready_d;
            tag_q       <= tag_d;
            s1_valid_q  <= s1_valid_d;
            s1_miss_q   <= s1_miss_d;
            s1_sel_q    <= s1_sel_d;
            s1_hcount_q <= s1_hcount_d;
            s1_vcount_q <= s1_vcount_d;
            pix_q       <= pix_d;
            hcount_q    <= hcount_d;
            vcount_q    <= vcount_d;
            valid_q     <= valid_d;
            miss_q      <= miss_d;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_bank
        upscale_line_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (BCOLS),
            .AW         (BAW)
        ) u_bank (
            .clk_in  (clk_in),
            .wr_en   (data_valid_in & ~rst_in & (wr_bank == 1'(i))),
            .wr_addr (hcount_in),
            .wr_data (pixel_data_in),
            .rd_en   (disp_valid_in),
            .rd_addr (rd_col),
            .rd_data (rd_data[i])
        );
    end

    assign pixel_data_out = pix_q;
    assign hcount_out     = hcount_q;
    assign vcount_out     = vcount_q;
    assign data_valid_out = valid_q;
    assign row_miss_out   = miss_q;

endmodule

// File: tb/tb_mask_upscaler.sv
// Self-checking bench for mask_upscaler against a per-position reference model of the two line banks.
module tb_mask_upscaler;

    localparam int HRES  = 1280;
    localparam int VRES  = 720;
    localparam int K     = 4;
    localparam int BCOLS = HRES / K;
    localparam int BROWS = VRES / K;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [8:0]  hcount_in = '0;
    logic [7:0]  vcount_in = '0;
    logic [0:0]  pixel_data_in = '0;
    logic        data_valid_in = 1'b0;
    logic [10:0] hcount_disp_in = '0;
    logic [9:0]  vcount_disp_in = '0;
    logic        disp_valid_in = 1'b0;
    logic [0:0]  pixel_data_out;
    logic [10:0] hcount_out;
    logic [9:0]  vcount_out;
    logic        data_valid_out;
    logic        row_miss_out;

    mask_upscaler dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .hcount_in      (hcount_in),
        .vcount_in      (vcount_in),
        .pixel_data_in  (pixel_data_in),
        .data_valid_in  (data_valid_in),
        .hcount_disp_in (hcount_disp_in),
        .vcount_disp_in (vcount_disp_in),
        .disp_valid_in  (disp_valid_in),
        .pixel_data_out (pixel_data_out),
        .hcount_out     (hcount_out),
        .vcount_out     (vcount_out),
        .data_valid_out (data_valid_out),
        .row_miss_out   (row_miss_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int pix;
        int h;
        int v;
        int valid;
        int miss;
    } exp_t;

    exp_t q[$];
    bit   m_mem [2][BCOLS];
    bit   m_rdy [2];
    int   m_tag [2];
    int   checks   = 0;
    int   failures = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: check the output due now, then present inputs and advance the model.
    task automatic step(input bit rst, input bit wv, input int wh, input int wr, input int wp,
                        input bit dv, input int dh, input int dr);
        exp_t e;
        exp_t z;
        int   r, c, b;
        bit   hit;
        @(negedge clk_in);
        if (q.size() >= 2) begin
            e = q.pop_front();
            check_val("pixel", 32'(pixel_data_out), e.pix);
            check_val("hcount", 32'(hcount_out), e.h);
            check_val("vcount", 32'(vcount_out), e.v);
            check_val("valid", 32'(data_valid_out), e.valid);
            check_val("row_miss", 32'(row_miss_out), e.miss);
        end
        rst_in         = rst;
        data_valid_in  = wv;
        hcount_in      = 9'(wh);
        vcount_in      = 8'(wr);
        pixel_data_in  = 1'(wp);
        disp_valid_in  = dv;
        hcount_disp_in = 11'(dh);
        vcount_disp_in = 10'(dr);
        z = '{0, 0, 0, 0, 0};
        if (rst) begin
            q.delete();
            q.push_back(z);
            q.push_back(z);
            m_rdy = '{0, 0};
            m_tag = '{0, 0};
            return;
        end
        r = dr / K;
        c = dh / K;
        b = r % 2;
        hit = dv && m_rdy[b] && (m_tag[b] == r);
        e.h = dh;
        e.v = dr;
        e.valid = dv;
        e.miss = (dv && !hit) ? 1 : 0;
        e.pix = hit ? int'(m_mem[b][c]) : 0;
`ifdef UPSCALER_MISS_HOLD_EN
        if (dv && !hit && m_rdy[1-b]) e.pix = int'(m_mem[1-b][c]);
`endif
        q.push_back(e);
        if (hit && dh == HRES - 1 && (dr % K) == K - 1) m_rdy[b] = 0;
        if (wv) begin
            m_mem[wr % 2][wh] = wp[0];
            if (wh == 0) m_rdy[wr % 2] = 0;
            if (wh == BCOLS - 1) begin
                m_rdy[wr % 2] = 1;
                m_tag[wr % 2] = wr;
            end
        end
    endtask

    task automatic write_row(input int row, input int pat);
        for (int col = 0; col < BCOLS; col++) begin
            step(0, 1, col, row, (pat == 0) ? (col & 1) : int'($urandom_range(0, 1)), 0, 0, 0);
        end
    endtask

    // Display one full-res line, optionally writing a binned row from column wcol0 starting at cycle wstart.
    task automatic run_line(input int v, input int wrow, input int wcol0, input int wstart, input int rst_at);
        for (int i = 0; i < HRES; i++) begin
            bit rst;
            bit wv;
            int col;
            rst = (rst_at >= 0) && (i >= rst_at) && (i < rst_at + 3);
            col = wcol0 + i - wstart;
            wv  = (wrow >= 0) && (i >= wstart) && (col < BCOLS) && !rst;
            step(rst, wv, wv ? col : 0, wv ? wrow : 0, int'($urandom_range(0, 1)), 1, i, v);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 0, 0, 0, 0);

        write_row(0, 0);
        for (int v = 0; v < 4; v++) run_line(v, -1, 0, 0, -1);
        run_line(4, -1, 0, 0, -1);
        write_row(1, 1);
        for (int v = 4; v < 8; v++) run_line(v, -1, 0, 0, -1);

        // Refill row 0's bank, then end a row-2 write on the same cycle row 0 is released.
        write_row(0, 1);
        for (int v = 0; v < 3; v++) run_line(v, -1, 0, 0, -1);
        run_line(3, 2, BCOLS - 1, HRES - 1, -1);
        run_line(8, -1, 0, 0, -1);
        run_line(9, 3, 0, 0, -1);

        for (int n = 0; n < 3000; n++) begin
            int  b, dh, dr, wh, wr;
            bit  dv, wv;
            b  = int'($urandom_range(0, 1));
            dv = ($urandom_range(0, 3) != 0);
            dh = ($urandom_range(0, 7) == 0) ? HRES - 1 : int'($urandom_range(0, HRES - 1));
            if (m_rdy[b] && $urandom_range(0, 1) == 1) dr = m_tag[b] * K + int'($urandom_range(0, K - 1));
            else dr = int'($urandom_range(0, VRES - 1));
            wv = ($urandom_range(0, 1) == 1);
            wr = int'($urandom_range(0, BROWS - 1));
            case ($urandom_range(0, 3))
                0:       wh = 0;
                1:       wh = BCOLS - 1;
                default: wh = int'($urandom_range(0, BCOLS - 1));
            endcase
            step(0, wv, wh, wr, int'($urandom_range(0, 1)), dv, dh, dr);
        end

        write_row(BROWS - 1, 1);
        for (int v = VRES - 4; v < VRES; v++) run_line(v, -1, 0, 0, -1);
        write_row(0, 1);
        for (int v = 0; v < 4; v++) run_line(v, -1, 0, 0, -1);

        write_row(1, 1);
        run_line(4, -1, 0, 0, 100);
        run_line(4, -1, 0, 0, -1);
        write_row(1, 1);
        run_line(4, -1, 0, 0, -1);
        run_line(8, -1, 0, 0, -1);

        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
